// File: rtl/pc_sequencer_if.sv
// Bus between the PC register block and the next-PC sequencer.
// master: PC/control side; drives ppc and the request inputs, observes next and status.
// slave:  the sequencer; consumes the requests, produces next, flush, epc, in_isr and state.
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] ppc;
  logic             stall;
  logic             halt;
  logic             jump;
  logic [WIDTH-1:0] jump_target;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             irq;
  logic             iret;
  logic [WIDTH-1:0] next;
  logic             flush;
  logic [WIDTH-1:0] epc;
  logic             in_isr;
  logic [1:0]       state;

  modport master (
    output ppc, stall, halt, jump, jump_target, branch_taken, branch_target, irq, iret,
    input  next, flush, epc, in_isr, state
  );

  modport slave (
    input  ppc, stall, halt, jump, jump_target, branch_taken, branch_target, irq, iret,
    output next, flush, epc, in_isr, state
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller. Picks the value the PC register loads on the next edge
// (sequential, jump/branch redirect, interrupt entry, return, stall hold, halt)
// and owns the BOOT/RUN/ISR/HALT state machine plus the saved return address.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset
//   seq_io - pc_sequencer_if.slave: ppc and request inputs in; next, flush
//            (combinational) and epc, in_isr, state (registered) out
module pc_sequencer #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [WIDTH-1:0] IRQ_VEC   = 32'h0000_0010,
  parameter logic [WIDTH-1:0] STEP      = 32'd4
) (
  input  logic            clk,
  input  logic            reset,
  pc_sequencer_if.slave   seq_io
);

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StIsr  = 2'd2,
    StHalt = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             in_isr_q, in_isr_d;
  logic [WIDTH-1:0] seq_addr;

  // Address from the low-priority rules (jump > branch > increment). Also the
  // return address captured on interrupt entry, so a same-cycle redirect survives.
  always_comb begin
    seq_addr = seq_io.ppc + STEP;  // carry discarded: wraps modulo 2^WIDTH
    if (seq_io.jump) begin
      seq_addr = seq_io.jump_target;
    end else if (seq_io.branch_taken) begin
      seq_addr = seq_io.branch_target;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StBoot;
      epc_q    <= '0;
      in_isr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      epc_q    <= epc_d;
      in_isr_q <= in_isr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (seq_io.halt) begin
          state_d = StHalt;
        end else if (seq_io.stall) begin
          state_d = StRun;
        end else if (seq_io.irq) begin
          state_d = StIsr;
          epc_d   = seq_addr;
        end
      end
      StIsr: begin
        if (seq_io.halt) begin
          state_d = StHalt;
        end else if (seq_io.stall) begin
          state_d = StIsr;
        end else if (seq_io.iret) begin
          state_d = StRun;
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StBoot;
    endcase
    in_isr_d = (state_d == StIsr);
  end

  // Output logic
  always_comb begin
    seq_io.next  = seq_io.ppc;
    seq_io.flush = 1'b0;
    unique case (state_q)
      StBoot: seq_io.next = RESET_VEC;
      StRun: begin
        if (seq_io.halt || seq_io.stall) begin
          seq_io.next = seq_io.ppc;
        end else if (seq_io.irq) begin
          seq_io.next  = IRQ_VEC;
          seq_io.flush = 1'b1;
        end else begin
          seq_io.next  = seq_addr;
          seq_io.flush = seq_io.jump || seq_io.branch_taken;
        end
      end
      StIsr: begin
        if (seq_io.halt || seq_io.stall) begin
          seq_io.next = seq_io.ppc;
        end else if (seq_io.iret) begin
          seq_io.next  = epc_q;
          seq_io.flush = 1'b1;
        end else begin
          seq_io.next  = seq_addr;
          seq_io.flush = seq_io.jump || seq_io.branch_taken;
        end
      end
      StHalt: seq_io.next = seq_io.ppc;
      default: seq_io.next = RESET_VEC;
    endcase
  end

  assign seq_io.epc    = epc_q;
  assign seq_io.in_isr = in_isr_q;
  assign seq_io.state  = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] pc_q;
  logic        load_en;
  logic [31:0] load_val;
  int          n_checks;
  int          n_pass;

  pc_sequencer_if #(.WIDTH(32)) seq_if ();

  pc_sequencer #(
    .WIDTH    (32),
    .RESET_VEC(32'h0000_0000),
    .IRQ_VEC  (32'h0000_0010),
    .STEP     (32'd4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .seq_io(seq_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PC register model: loads next every edge unless the bench overrides it.
  always @(posedge clk) pc_q <= load_en ? load_val : seq_if.next;
  assign seq_if.ppc = pc_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_req();
    seq_if.stall         = 1'b0;
    seq_if.halt          = 1'b0;
    seq_if.jump          = 1'b0;
    seq_if.jump_target   = 32'h0;
    seq_if.branch_taken  = 1'b0;
    seq_if.branch_target = 32'h0;
    seq_if.irq           = 1'b0;
    seq_if.iret          = 1'b0;
  endtask

  task automatic load_pc(input logic [31:0] val);
    load_en  = 1'b1;
    load_val = val;
    step();
    load_en  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    load_en  = 1'b0;
    load_val = 32'h0;
    reset    = 1'b0;
    clear_req();

    // Reset held for two cycles
    step();
    step();
    chk("rst_next", seq_if.next, 32'h0);
    chk("rst_flush", {31'b0, seq_if.flush}, 32'h0);
    chk("rst_state", {30'b0, seq_if.state}, 32'd0);
    chk("rst_epc", seq_if.epc, 32'h0);
    chk("rst_in_isr", {31'b0, seq_if.in_isr}, 32'h0);
    chk("rst_ppc", pc_q, 32'h0);

    // Boot
    reset = 1'b1;
    settle();
    chk("boot_next", seq_if.next, 32'h0);
    step();
    chk("boot_ppc0", pc_q, 32'h0);
    chk("run_state", {30'b0, seq_if.state}, 32'd1);
    step();
    chk("seq_ppc4", pc_q, 32'h4);
    step();
    chk("seq_ppc8", pc_q, 32'h8);

    // Jump wins over branch
    seq_if.jump          = 1'b1;
    seq_if.jump_target   = 32'h100;
    seq_if.branch_taken  = 1'b1;
    seq_if.branch_target = 32'h200;
    settle();
    chk("jmp_next", seq_if.next, 32'h100);
    chk("jmp_flush", {31'b0, seq_if.flush}, 32'h1);
    step();
    chk("jmp_ppc", pc_q, 32'h100);
    clear_req();

    // Increment wraps
    load_pc(32'hFFFF_FFFC);
    chk("wrap_next", seq_if.next, 32'h0);
    chk("wrap_flush", {31'b0, seq_if.flush}, 32'h0);
    step();
    chk("wrap_ppc", pc_q, 32'h0);

    // Stall beats jump for three cycles
    load_pc(32'h10);
    seq_if.stall       = 1'b1;
    seq_if.jump        = 1'b1;
    seq_if.jump_target = 32'h300;
    settle();
    chk("stall_next", seq_if.next, 32'h10);
    chk("stall_flush", {31'b0, seq_if.flush}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ppc", pc_q, 32'h10);
    end
    clear_req();
    settle();
    chk("unstall_next", seq_if.next, 32'h14);
    step();
    chk("unstall_ppc", pc_q, 32'h14);

    // Interrupt with same-cycle branch
    load_pc(32'h20);
    seq_if.irq           = 1'b1;
    seq_if.branch_taken  = 1'b1;
    seq_if.branch_target = 32'h40;
    settle();
    chk("irq_next", seq_if.next, 32'h10);
    chk("irq_flush", {31'b0, seq_if.flush}, 32'h1);
    step();
    chk("isr_ppc", pc_q, 32'h10);
    chk("isr_epc", seq_if.epc, 32'h40);
    chk("isr_in_isr", {31'b0, seq_if.in_isr}, 32'h1);
    chk("isr_state", {30'b0, seq_if.state}, 32'd2);
    seq_if.branch_taken = 1'b0;
    settle();
    chk("nonest_next", seq_if.next, 32'h14);
    step();
    chk("nonest_ppc", pc_q, 32'h14);
    chk("nonest_state", {30'b0, seq_if.state}, 32'd2);
    seq_if.iret = 1'b1;
    settle();
    chk("iret_next", seq_if.next, 32'h40);
    chk("iret_flush", {31'b0, seq_if.flush}, 32'h1);
    step();
    chk("iret_ppc", pc_q, 32'h40);
    chk("iret_in_isr", {31'b0, seq_if.in_isr}, 32'h0);
    chk("iret_state", {30'b0, seq_if.state}, 32'd1);
    clear_req();

    // Re-enter ISR, then halt inside it
    seq_if.irq = 1'b1;
    step();
    seq_if.irq = 1'b0;
    chk("isr2_epc", seq_if.epc, 32'h44);
    chk("isr2_ppc", pc_q, 32'h10);
    step();
    step();
    chk("isr2_ppc18", pc_q, 32'h18);
    seq_if.halt = 1'b1;
    settle();
    chk("halt_next", seq_if.next, 32'h18);
    step();
    chk("halt_state", {30'b0, seq_if.state}, 32'd3);
    chk("halt_ppc", pc_q, 32'h18);
    seq_if.halt        = 1'b0;
    seq_if.irq         = 1'b1;
    seq_if.iret        = 1'b1;
    seq_if.jump        = 1'b1;
    seq_if.jump_target = 32'h500;
    settle();
    chk("halt_ign_next", seq_if.next, 32'h18);
    chk("halt_ign_flush", {31'b0, seq_if.flush}, 32'h0);
    step();
    step();
    chk("halt_hold_ppc", pc_q, 32'h18);
    chk("halt_hold_state", {30'b0, seq_if.state}, 32'd3);

    // Asynchronous reset mid-cycle
    #2;
    reset = 1'b0;
    settle();
    chk("arst_state", {30'b0, seq_if.state}, 32'd0);
    chk("arst_epc", seq_if.epc, 32'h0);
    chk("arst_in_isr", {31'b0, seq_if.in_isr}, 32'h0);
    chk("arst_next", seq_if.next, 32'h0);
    chk("arst_flush", {31'b0, seq_if.flush}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
